ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//  Parametrised multiplexed hex display driver: scans NUM_DIGITS hex nibbles onto one shared
//  7-segment bus with per-digit enables. Handshaked, tear-free loading of new values.
//  Leading-zero blanking and ghosting guard. Sits between ALU/UART result logic and board SSD pins.
// PARAMETERS
//  NUM_DIGITS      4     digits scanned, 1..8
//  REFRESH_CYCLES  1000  clk cycles per digit slot, >= 2
//  GUARD_CYCLES    2     cycles at start of each slot with all digits off, < REFRESH_CYCLES
//  SEG_ACTIVE_LOW  1     1: segment on = 0; 0: segment on = 1
//  DIG_ACTIVE_LOW  1     1: digit enabled = 0; 0: digit enabled = 1
//  BLANK_LZ        1     1: suppress leading zeros
// PORTS
//  clk_i      in   1             clock
//  reset_i    in   1             async reset, active-high
//  data_i     in   4*NUM_DIGITS  value to show, nibble k = digit k (k=0 rightmost)
//  valid_i    in   1             data_i valid
//  ready_o    out  1             pending buffer empty; accept when valid_i & ready_o
//  blank_i    in   1             force all digits off; scan keeps running
//  ssd_o      out  7             segments {g,f,e,d,c,b,a}
//  dig_o      out  NUM_DIGITS    digit enables, one active at most
// BEHAVIOUR
//  - Reset (async, while reset_i high):
//    - display reg = 0, pending empty, ready_o = 1;
//    - slot counter = 0, digit index = 0;
//    - ssd_o all segments off, dig_o all inactive.
//  - Storage: one pending reg + one display reg.
//    - Accept (valid_i & ready_o) writes pending; ready_o goes 0 the next cycle.
//    - At frame wrap (last cycle of digit NUM_DIGITS-1 slot), a full pending moves to display.
//    - ready_o returns to 1 the next cycle. No bypass: data accepted in the wrap cycle waits one full frame.
//    - valid_i with ready_o=0 is ignored; data_i must be held by the source.
//  - Scan:
//    - slot counter counts 0..REFRESH_CYCLES-1, then wraps to 0 and increments the digit index.
//    - Digit index wraps NUM_DIGITS-1 -> 0.
//  - Outputs are registered, one cycle after counter/index state.
//    - Slot counter < GUARD_CYCLES: dig_o all inactive, ssd_o off.
//    - Otherwise dig_o enables the current digit and ssd_o = glyph(display nibble).
//  - Glyphs, active-low hex:
//    - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    - 8:00 9:18 A:08 B:03 C:46 D:21 E:06 F:0E
//    - SEG_ACTIVE_LOW=0 drives the bitwise inverse.
//  - Leading-zero blanking (BLANK_LZ=1):
//    - digit k>0 is blanked if nibbles k..NUM_DIGITS-1 of display are all 0;
//    - digit 0 is never blanked.
//    - Blanked slot: dig_o inactive, ssd_o off.
//  - blank_i is sampled each cycle. While high: dig_o inactive, ssd_o off; counters, handshake and pending unaffected.
//  - Reset mid-frame drops pending and display contents; scan restarts at digit 0, slot cycle 0.
// TESTING (NUM_DIGITS=4, REFRESH_CYCLES=8, GUARD_CYCLES=1, active-low, BLANK_LZ=1)
//  1. Reset high: ssd_o=7'h7F, dig_o=4'hF, ready_o=1. Release: digit0 shows "0" (ssd_o=7'h40,
//     dig_o=4'b1110) for 7 cycles after 1 guard cycle; digits 1-3 stay off.
//  2. Load 16'h1234 mid-frame: ready_o=0 next cycle until wrap+1.
//     Next frame, per slot: digit0 7'h19/4'b1110, digit1 7'h30/4'b1101,
//     digit2 7'h24/4'b1011, digit3 7'h79/4'b0111.
//  3. Back-to-back loads 16'h1234 then 16'hABCD: second held (ready_o=0) until the first-load wrap;
//     16'hABCD accepted after it and displayed one frame later; no value lost or torn.
//  4. Load 16'h0005: digits 3..1 dig_o=4'hF during their slots; digit0 ssd_o=7'h12.
//     Load 16'h0000: only digit0 shows 7'h40.
//  5. Assert reset_i mid-slot with a pending value: outputs off immediately.
//     After release, ready_o=1 and only "0" is shown.
//  6. blank_i high for one frame: dig_o=4'hF throughout, ready_o/pending transfer unchanged.
//     SEG_ACTIVE_LOW=0: digit "8" gives ssd_o=7'h7F.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed hex 7-segment scanner with handshaked tear-free loading.
// Ports: clk_i/reset_i clock and async active-high reset; data_i/valid_i/ready_o load
// handshake (nibble k = digit k); blank_i forces the display dark; ssd_o {g..a} segments;
// dig_o per-digit enables.
module ssd_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 1000,
  parameter int GUARD_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit DIG_ACTIVE_LOW = 1,
  parameter bit BLANK_LZ       = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    blank_i,
  output logic [6:0]              ssd_o,
  output logic [NUM_DIGITS-1:0]   dig_o
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] pend, disp;
  logic full, slot_end, last_dig, wrap, accept, lz, on, run;
  logic [3:0] nib;
  logic [6:0] glyph;
  logic [NUM_DIGITS-1:0] hot;
  assign slot_end = cnt == CW'(REFRESH_CYCLES - 1);
  assign last_dig = idx == IW'(NUM_DIGITS - 1);
  assign wrap     = slot_end && last_dig;
  assign accept   = valid_i && !full;
  assign ready_o  = !full;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= last_dig ? '0 : idx + 1'b1;
    end
  end
  // Accept only when empty, so a load and a frame-wrap transfer never coincide;
  // a value accepted in the wrap cycle waits for the next wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend <= '0;
      disp <= '0;
      full <= 1'b0;
    end else if (accept) begin
      pend <= data_i;
      full <= 1'b1;
    end else if (wrap && full) begin
      disp <= pend;
      full <= 1'b0;
    end
  end
  // Walk from the top digit down: run stays set while every nibble so far is zero,
  // which is exactly the leading-zero condition for the digit being visited.
  always_comb begin
    nib = '0;
    lz  = 1'b0;
    hot = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run = run && (disp[4*k +: 4] == 4'd0);
      if (IW'(k) == idx) begin
        nib    = disp[4*k +: 4];
        lz     = run && (k > 0);
        hot[k] = 1'b1;
      end
    end
  end
  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end
  assign on = !blank_i && (cnt >= CW'(GUARD_CYCLES)) && !(BLANK_LZ && lz);
  // Build active-high patterns, then flip to the board polarity in one XOR.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ssd_o <= {7{SEG_ACTIVE_LOW}};
      dig_o <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      ssd_o <= (on ? ~glyph : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
      dig_o <= (on ? hot : '0) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: table vectors plus random traffic against a time-arithmetic model.
module tb_ssd_scan_driver;
  localparam int N = 4, R = 8, G = 1, F = N * R;
  logic clk = 0, rst = 1, valid = 0, blank = 0;
  logic [15:0] data = '0;
  logic ready, ready2;
  logic [6:0] ssd, ssd2;
  logic [3:0] dig, dig2;
  int n_cmp = 0, n_bad = 0, t = 0, last_slot = 0, last_d = 0;
  logic [15:0] m_pend = '0, m_disp = '0;
  bit m_full = 0, last_acc = 0;
  logic [6:0] gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct {
    logic [15:0] val;
    logic [3:0][6:0] s;
    logic [3:0][3:0] d;
  } vec_t;
  vec_t tab [6];
  always #5 clk = ~clk;
  ssd_scan_driver #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .GUARD_CYCLES(G),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLANK_LZ(1)) dut (
    .clk_i(clk), .reset_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
    .blank_i(blank), .ssd_o(ssd), .dig_o(dig));
  ssd_scan_driver #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .GUARD_CYCLES(G),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0), .BLANK_LZ(1)) dut2 (
    .clk_i(clk), .reset_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready2),
    .blank_i(blank), .ssd_o(ssd2), .dig_o(dig2));
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
    end
  endtask
  task automatic model_reset();
    t = 0; m_pend = '0; m_disp = '0; m_full = 0;
  endtask
  // One clock: expected outputs come from the display value and the position in the frame
  // implied by the cycle number since reset.
  task automatic step();
    int sl, d;
    bit on, acc;
    logic [3:0] nb;
    logic [6:0] es, es2;
    logic [3:0] ed, ed2;
    sl = t % R;
    d = (t / R) % N;
    nb = m_disp[4*d +: 4];
    on = !blank && sl >= G && !(d > 0 && (m_disp >> (4 * d)) == 16'h0);
    es = on ? gly[nb] : 7'h7F;
    ed = on ? ~(4'b1 << d) : 4'hF;
    es2 = on ? ~gly[nb] : 7'h00;
    ed2 = on ? (4'b1 << d) : 4'h0;
    acc = valid && !m_full;
    if (t % F == F - 1 && m_full) begin m_disp = m_pend; m_full = 0; end
    if (acc) begin m_pend = data; m_full = 1; end
    last_acc = acc; last_slot = sl; last_d = d;
    t++;
    @(posedge clk); #1;
    chk("ssd", 32'(ssd), 32'(es));
    chk("dig", 32'(dig), 32'(ed));
    chk("ssd_hi", 32'(ssd2), 32'(es2));
    chk("dig_hi", 32'(dig2), 32'(ed2));
    chk("ready", 32'(ready), 32'(!m_full));
  endtask
  task automatic load(logic [15:0] v);
    int k = 0;
    valid = 1; data = v;
    do begin step(); k++; end while (!last_acc && k < 200);
    chk("load_accepted", 32'(last_acc), 32'd1);
    valid = 0;
  endtask
  task automatic show(vec_t v);
    int k = 0;
    load(v.val);
    while (m_disp != v.val && k < 3 * F) begin step(); k++; end
    chk("display_reached", 32'(m_disp == v.val), 32'd1);
    for (int i = 0; i < F; i++) begin
      step();
      if (last_slot == 4) begin
        chk("tab_ssd", 32'(ssd), 32'(v.s[last_d]));
        chk("tab_dig", 32'(dig), 32'(v.d[last_d]));
      end
    end
  endtask
  initial begin
    tab[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    tab[1] = '{16'h0005, {7'h7F, 7'h7F, 7'h7F, 7'h12}, {4'hF, 4'hF, 4'hF, 4'b1110}};
    tab[2] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'hF, 4'hF, 4'hF, 4'b1110}};
    tab[3] = '{16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    tab[4] = '{16'hF0E0, {7'h0E, 7'h40, 7'h06, 7'h40}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    tab[5] = '{16'h0800, {7'h7F, 7'h00, 7'h40, 7'h40}, {4'hF, 4'b1011, 4'b1101, 4'b1110}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ssd", 32'(ssd), 32'h7F);
    chk("rst_dig", 32'(dig), 32'hF);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ssd_hi", 32'(ssd2), 32'h00);
    rst = 0;
    model_reset();
    repeat (F + 5) step();
    for (int i = 0; i < 6; i++) show(tab[i]);
    // back-to-back: second value must wait for the first wrap, then show a frame later
    load(16'h1234);
    valid = 1; data = 16'hABCD;
    begin
      int k = 0;
      do begin step(); k++; end while (!last_acc && k < 3 * F);
      chk("b2b_second_accepted", 32'(last_acc), 32'd1);
    end
    valid = 0;
    repeat (2 * F + 3) step();
    show(tab[0]);
    // async reset in the middle of a slot with a value pending
    load(16'h9876);
    repeat (3) step();
    #3 rst = 1;
    #1;
    chk("arst_ssd", 32'(ssd), 32'h7F);
    chk("arst_dig", 32'(dig), 32'hF);
    chk("arst_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    repeat (2 * F) step();
    // blank for a frame while a load and a transfer happen underneath
    blank = 1;
    load(16'h8888);
    repeat (F) step();
    blank = 0;
    repeat (F) step();
    for (int i = 0; i < 1500; i++) begin
      blank = $urandom_range(0, 9) == 0;
      if (!(valid && m_full)) begin
        valid = $urandom_range(0, 3) == 0;
        data = 16'($urandom) & {{4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}},
                                {4{1'($urandom_range(0, 1))}}, 4'hF};
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
